// File: rtl/node_pkg.sv
// +--------------------------------------------------------------------+
// | node_pkg: shared types for the node datapath and its sequencer     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } node_seq_state_t;

    localparam int DEFAULT_IMAGE_SIZE = 64;

    // 16-bit fixed-point word used by the node datapath
    typedef logic [15:0] double;

endpackage

`default_nettype wire

// File: rtl/seq_index_counter.sv
// +--------------------------------------------------------------------+
// | seq_index_counter: loadable index counter, stops at TERMINAL       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_index_counter #(
    parameter int CNT_W    = 7,
    parameter int TERMINAL = 63
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TERMINAL);

    assign terminal = (count == TC_VALUE);

    // Holds at the terminal value instead of wrapping
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/node_sequencer.sv
// +--------------------------------------------------------------------+
// | node_sequencer: drives one node MAC through an IMAGE_SIZE dot      |
// | product. Optional NODE_SEQUENCER_PERF_EN adds cycle_count.   Rev 1.0|
// +--------------------------------------------------------------------+
`default_nettype none

module node_sequencer
    import node_pkg::*;
#(
    parameter int IMAGE_SIZE = DEFAULT_IMAGE_SIZE,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             go,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             node_reset_acc,
    output logic             node_start,
    output logic [CNT_W-1:0] cnt_val,
    output logic             result_valid,
    input  logic             result_ack,
`ifdef NODE_SEQUENCER_PERF_EN
    output logic [15:0]      cycle_count,
`endif
    output logic             done_pulse
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_CLEAR = CLEAR;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       last_index;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (go) next_state = ST_CLEAR;
            ST_CLEAR: next_state = abort ? ST_IDLE : ST_ACCUM;
            ST_ACCUM: begin
                if (abort)           next_state = ST_IDLE;
                else if (last_index) next_state = ST_DONE;
            end
            ST_DONE:  if (abort || result_ack) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            done_pulse <= 1'b0;
        end else begin
            state      <= next_state;
            done_pulse <= (state == ST_ACCUM) && (next_state == ST_DONE);
        end
    end

    // Index returns to zero whenever the pass ends, so IDLE always shows 0
    seq_index_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (IMAGE_SIZE - 1)
    ) u_index (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (next_state == ST_IDLE),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .enable   (state == ST_ACCUM),
        .count    (cnt_val),
        .terminal (last_index)
    );

    assign ready          = (state == ST_IDLE);
    assign busy           = (state == ST_CLEAR) || (state == ST_ACCUM);
    assign node_reset_acc = (state == ST_CLEAR);
    assign node_start     = (state != ST_ACCUM);
    assign result_valid   = (state == ST_DONE);

`ifdef NODE_SEQUENCER_PERF_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cycle_count <= '0;
        end else if (state == ST_IDLE) begin
            if (go) cycle_count <= '0;
        end else if (cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_node_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_node_sequencer: self-checking bench for node_sequencer          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_node_sequencer;

    localparam int N  = 64;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          go = 1'b0, abort = 1'b0, result_ack = 1'b0;
    logic          ready, busy, node_reset_acc, node_start, result_valid, done_pulse;
    logic [CW-1:0] cnt_val;
`ifdef NODE_SEQUENCER_PERF_EN
    logic [15:0]   cycle_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    node_sequencer #(.IMAGE_SIZE(N), .CNT_W(CW)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .go             (go),
        .abort          (abort),
        .ready          (ready),
        .busy           (busy),
        .node_reset_acc (node_reset_acc),
        .node_start     (node_start),
        .cnt_val        (cnt_val),
        .result_valid   (result_valid),
        .result_ack     (result_ack),
`ifdef NODE_SEQUENCER_PERF_EN
        .cycle_count    (cycle_count),
`endif
        .done_pulse     (done_pulse)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] mk(bit r, bit b, bit ra, bit st, bit v, bit p, int c);
        return {r, b, ra, st, v, p, 7'(c)};
    endfunction

    wire [12:0] dut_vec = {ready, busy, node_reset_acc, node_start, result_valid, done_pulse, cnt_val};

    // Reference: a pass is a position p (0 = clear step, 1..N = index p-1, N+1 = result)
    bit          m_active;
    int          m_p, m_dc;
    int unsigned m_cc;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_active = 0; m_p = 0; m_dc = 0; m_cc = 0;
        end else if (!m_active) begin
            if (go) begin m_active = 1; m_p = 0; m_dc = 0; m_cc = 0; end
        end else begin
            if (m_cc != 32'hFFFF) m_cc++;
            if (abort)               m_active = 0;
            else if (m_p <= N)       m_p++;
            else if (result_ack)     m_active = 0;
            else                     m_dc++;
        end
    end

    function automatic logic [12:0] model_out();
        int c;
        bit v;
        c = (!m_active || m_p == 0) ? 0 : (m_p <= N ? m_p - 1 : N - 1);
        v = m_active && (m_p == N + 1);
        return mk(!m_active, m_active && m_p <= N, m_active && m_p == 0,
                  !(m_active && m_p >= 1 && m_p <= N), v, v && m_dc == 0, c);
    endfunction

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_outputs", dut_vec, model_out());
`ifdef NODE_SEQUENCER_PERF_EN
            chk("model_cycle_count", cycle_count, m_cc);
`endif
        end
    end

    // Attached node: accumulator driven by the sequencer's control outputs
    logic [15:0] coef [N];
    logic [15:0] data [N];
    longint      acc;
    int          n_racc, n_pulse;
    always @(posedge clk) begin
        if (node_reset_acc)   acc <= 0;
        else if (!node_start) acc <= acc + longint'(coef[cnt_val]) * longint'(data[cnt_val]);
        if (node_reset_acc) n_racc++;
        if (done_pulse)     n_pulse++;
    end

    function automatic longint exp_sum();
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(coef[i]) * longint'(data[i]);
        return s;
    endfunction

    task automatic run_pass(input bit noise, output int lat);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        lat = 1;
        while (!result_valid && lat < 200) begin
            if (noise) begin
                go         = 1'($urandom_range(0, 1));
                result_ack = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        go = 1'b0;
        result_ack = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int k = 0;
        while (cnt_val != CW'(target) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_cnt", k < 200, 1);
    endtask

    typedef struct {
        logic        go, abort, ack;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[12];

    int     lat;
    longint held;

    initial begin
        tbl[0]  = '{0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0)};
        tbl[1]  = '{1, 1, 0, mk(0, 1, 1, 1, 0, 0, 0)};
        tbl[2]  = '{1, 0, 0, mk(0, 1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1, 0, 1, mk(0, 1, 0, 0, 0, 0, 1)};
        tbl[4]  = '{0, 0, 0, mk(0, 1, 0, 0, 0, 0, 2)};
        tbl[5]  = '{0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{0, 0, 1, mk(1, 0, 0, 1, 0, 0, 0)};
        tbl[7]  = '{1, 0, 0, mk(0, 1, 1, 1, 0, 0, 0)};
        tbl[8]  = '{0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0)};
        tbl[9]  = '{1, 0, 0, mk(0, 1, 1, 1, 0, 0, 0)};
        tbl[10] = '{0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0)};
        tbl[11] = '{0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0)};

        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", dut_vec, mk(1, 0, 0, 1, 0, 0, 0));
        n_rst = 1'b1;
        chk_en = 1;
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            go = tbl[i].go; abort = tbl[i].abort; result_ack = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d", i), dut_vec, tbl[i].exp);
        end
        go = 0; abort = 0; result_ack = 0;

        // Basic pass, then hold in DONE for 20 cycles
        foreach (coef[i]) begin coef[i] = 16'h0100; data[i] = 16'h0100; end
        n_racc = 0; n_pulse = 0;
        run_pass(0, lat);
        chk("basic_latency", lat, 66);
        chk("basic_sum", acc, exp_sum());
        held = acc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_cnt", {node_start, result_valid, cnt_val}, {2'b11, CW'(N - 1)});
        end
        chk("hold_acc", acc, held);
        chk("reset_acc_width", n_racc, 1);
        chk("done_pulse_width", n_pulse, 1);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk("ack_to_ready", ready, 1);

        // Abort mid-pass, then a clean pass acked on its first DONE cycle
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_cnt(30);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("abort_idle", {ready, result_valid}, 2'b10);
        foreach (coef[i]) begin coef[i] = 16'($urandom); data[i] = 16'($urandom); end
        run_pass(0, lat);
        chk("after_abort_sum", acc, exp_sum());
        result_ack = 1'b1; @(negedge clk); result_ack = 1'b0;
`ifdef NODE_SEQUENCER_PERF_EN
        chk("perf_cycle_count", cycle_count, 66);
`endif

        // Ignored go/ack during ACCUM, then abort+ack together in DONE
        run_pass(1, lat);
        chk("noisy_latency", lat, 66);
        @(negedge clk);
        abort = 1'b1; result_ack = 1'b1;
        @(negedge clk);
        abort = 1'b0; result_ack = 1'b0;
        chk("abort_ack_idle", ready, 1);

        // Asynchronous reset mid-pass, observed before any clock edge
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_cnt(10);
        #2 n_rst = 1'b0;
        #1 chk("async_reset", dut_vec, mk(1, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            go         = ($urandom_range(0, 19) == 0);
            abort      = ($urandom_range(0, 99) == 0);
            result_ack = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/node_sequencer.md
Name: node_sequencer

Overview:
- Controller that drives one `node` MAC datapath through a full dot product over IMAGE_SIZE coefficient/data pairs.
- Issues the accumulator clear, steps `cnt_val` through every index, then freezes the accumulator and presents the activated result with a valid/ack handshake.
- Sits between the layer-level control FSM (go/ready, result_valid/result_ack) and the node's control inputs (`reset_acc`, `start`, `cnt_val`).

Parameters:
- IMAGE_SIZE, 64: number of coef/data pairs per dot product; legal range 2..2**CNT_W.
- CNT_W, 7: width of `cnt_val`; must match the node's `cnt_val` port.

Ports:
- clk, input, 1: system clock, rising edge.
- n_rst, input, 1: asynchronous active-low reset.
- go, input, 1: request one dot-product pass; sampled only while ready=1.
- abort, input, 1: synchronous abandon of the current pass.
- ready, output, 1: high only in IDLE.
- busy, output, 1: high in CLEAR or ACCUM.
- node_reset_acc, output, 1: drives the node's `reset_acc`.
- node_start, output, 1: drives the node's `start`; 1 = hold accumulator, 0 = accumulate.
- cnt_val, output, CNT_W: index driven to the node.
- result_valid, output, 1: the node's `node_out` holds the final activated result.
- result_ack, input, 1: consumer accepted the result.
- done_pulse, output, 1: single-cycle strobe on entry to DONE.

Behaviour:
- Registered Moore FSM with states IDLE, CLEAR, ACCUM, DONE. All outputs decode from registered state and count.
- Reset (n_rst=0, asynchronous): state=IDLE, cnt_val=0, ready=1, node_start=1, node_reset_acc=0, busy=0, result_valid=0, done_pulse=0.
- IDLE
  - Outputs: ready=1, node_start=1, node_reset_acc=0, cnt_val=0.
  - go=1 moves to CLEAR.
- CLEAR (exactly 1 cycle)
  - Outputs: node_reset_acc=1, node_start=1, cnt_val=0, busy=1.
  - Next state is ACCUM.
- ACCUM (exactly IMAGE_SIZE cycles)
  - Outputs: node_reset_acc=0, node_start=0, busy=1.
  - cnt_val=0 on the first cycle, then increments by 1 each cycle.
  - When cnt_val==IMAGE_SIZE-1, the next state is DONE and cnt_val holds its value (no wrap).
- DONE
  - Outputs: node_start=1 (accumulator frozen), cnt_val held at IMAGE_SIZE-1, result_valid=1.
  - done_pulse=1 on the first DONE cycle only.
  - result_ack=1 moves to IDLE; cnt_val returns to 0.
- Latency: go accepted at edge t gives CLEAR during t+1, ACCUM during t+2..t+1+IMAGE_SIZE, and result_valid from cycle t+2+IMAGE_SIZE. That is 66 cycles for the default.
- go outside IDLE is ignored, with no queuing.
- result_ack outside DONE is ignored.
- abort=1 in any non-IDLE state moves to IDLE on the next edge.
  - The accumulator is not cleared by abort; the next pass's CLEAR handles it.
  - abort has priority over result_ack and over ACCUM completion.
- go and abort both high in IDLE: go wins, because abort has no effect in IDLE.
- Reset asserted mid-pass: immediate return to IDLE values; no partial result is flagged.

Optional Feature:
- Macro: NODE_SEQUENCER_PERF_EN.
- Defined:
  - Adds output cycle_count [15:0], reset value 0.
  - Cleared to 0 when go is accepted.
  - Increments on every cycle in CLEAR, ACCUM or DONE.
  - Saturates at 16'hFFFF.
  - Holds its value in IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package node_pkg holds:
  - the state enum node_seq_state_t {IDLE, CLEAR, ACCUM, DONE}, 2 bits;
  - localparam DEFAULT_IMAGE_SIZE=64;
  - the `double` 16-bit typedef already used by the datapath, moved there.
- One natural sub-module: seq_index_counter, a CNT_W-bit loadable counter with clear, enable and terminal-count flag at IMAGE_SIZE-1.
- The FSM stays in node_sequencer.

Test Plan:
- Reset then idle: hold n_rst=0 for 3 cycles, release, no go -> ready=1, node_start=1, cnt_val=0, result_valid=0 on every cycle.
- Basic pass: one-cycle go, all coef=16'h0100 and all data=16'h0100 on an attached node -> reset_acc high for exactly 1 cycle; cnt_val steps 0..63; result_valid rises 66 cycles after go; done_pulse is 1 cycle wide; node_out matches the activation of the 64-term sum.
- Hold in DONE: withhold result_ack for 20 cycles -> cnt_val stays 63, node_start=1, node_out stable; ack at cycle 20 gives ready=1 on the next cycle.
- Abort mid-pass: abort at cnt_val=30 -> IDLE next cycle, result_valid never asserts; a following go gives a correct sum with no carry-over from the aborted pass.
- Ignored inputs: go pulses during ACCUM and result_ack pulses during ACCUM -> no state change and pass length unchanged; simultaneous abort+result_ack in DONE -> IDLE.
- Async reset: drop n_rst at cnt_val=10 -> outputs reach reset values without a clock edge; with NODE_SEQUENCER_PERF_EN, cycle_count=66 after a full pass acked on its first DONE cycle.
